// File: rtl/uut_test_sequencer_if.sv
// Request/result handshake between the autotest/SD measurement logic and uut_test_sequencer.
// master drives requests and slave (the sequencer) returns status and results.
interface uut_test_sequencer_if #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 32
);
    logic               start_i;
    logic [SEL_W-1:0]   sel_i;
    logic [BLOCK_W-1:0] block_i;
    logic [KEY_W-1:0]   key_i;
    logic               encdec_i;
    logic [CNT_W-1:0]   timeout_i;
    logic               busy_o;
    logic               done_o;
    logic               timeout_o;
    logic [BLOCK_W-1:0] block_o;
    logic [CNT_W-1:0]   cycles_o;

    modport master (
        output start_i, sel_i, block_i, key_i, encdec_i, timeout_i,
        input  busy_o, done_o, timeout_o, block_o, cycles_o
    );

    modport slave (
        input  start_i, sel_i, block_i, key_i, encdec_i, timeout_i,
        output busy_o, done_o, timeout_o, block_o, cycles_o
    );
endinterface

// File: rtl/uut_test_sequencer.sv
// Sequencer that resets, runs and times one of N_UUT block-cipher units under test,
// then reports the captured output, measured latency and timeout status.
module uut_test_sequencer #(
    parameter int unsigned BLOCK_W    = 128,
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned N_UUT      = 1,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    uut_test_sequencer_if.slave      ctl,
    output logic [N_UUT-1:0]         rst_uut_o,
    output logic [BLOCK_W-1:0]       block_uut_o,
    output logic [KEY_W-1:0]         key_uut_o,
    output logic                     encdec_uut_o,
    input  logic [N_UUT*BLOCK_W-1:0] block_uut_i,
    input  logic [N_UUT-1:0]         end_signal_uut_i
);
    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   tmo_q;
    logic [RC_W-1:0]    rst_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [N_UUT-1:0]   sel_onehot;
    logic [BLOCK_W-1:0] sel_block;
    logic               sel_end;
    logic               sel_ok;
    logic               tmo_hit;

    // Loop-based selection keeps indexing in range for any N_UUT/SEL_W pairing.
    always_comb begin
        sel_onehot = '0;
        sel_block  = '0;
        sel_end    = 1'b0;
        for (int unsigned k = 0; k < N_UUT; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_block     = block_uut_i[k*BLOCK_W +: BLOCK_W];
                sel_end       = end_signal_uut_i[k];
            end
        end
    end

    assign sel_ok   = ({1'b0, ctl.sel_i} < (SEL_W+1)'(N_UUT));
    assign cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign tmo_hit  = (tmo_q != '0) && (cnt_next == tmo_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            tmo_q         <= '0;
            rst_cnt       <= '0;
            cnt           <= '0;
            rst_uut_o     <= '1;
            block_uut_o   <= '0;
            key_uut_o     <= '0;
            encdec_uut_o  <= 1'b0;
            ctl.busy_o    <= 1'b0;
            ctl.done_o    <= 1'b0;
            ctl.timeout_o <= 1'b0;
            ctl.block_o   <= '0;
            ctl.cycles_o  <= '0;
        end else begin
            ctl.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctl.start_i) begin
                        ctl.busy_o <= 1'b1;
                        if (sel_ok) begin
                            sel_q         <= ctl.sel_i;
                            block_uut_o   <= ctl.block_i;
                            key_uut_o     <= ctl.key_i;
                            encdec_uut_o  <= ctl.encdec_i;
                            tmo_q         <= ctl.timeout_i;
                            rst_cnt       <= '0;
                            cnt           <= '0;
                            ctl.timeout_o <= 1'b0;
                            state         <= RESET;
                        end else begin
                            ctl.timeout_o <= 1'b1;
                            ctl.cycles_o  <= '0;
                            ctl.done_o    <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                RESET: begin
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        rst_uut_o <= ~sel_onehot;
                        state     <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                RUN: begin
                    cnt <= cnt_next;
                    // End signal takes priority over a coincident timeout.
                    if (sel_end || tmo_hit) begin
                        ctl.block_o   <= sel_block;
                        ctl.cycles_o  <= cnt_next;
                        ctl.timeout_o <= ~sel_end;
                        ctl.done_o    <= 1'b1;
                        rst_uut_o     <= '1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    ctl.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uut_test_sequencer.sv
// Randomized bench for uut_test_sequencer: behavioural UUT models plus an arithmetic
// reference for latency, timeout status and captured output.
module tb_uut_test_sequencer;
    localparam int unsigned BW = 64;
    localparam int unsigned KW = 64;
    localparam int unsigned NU = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned RC = 4;
    localparam int unsigned CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NU-1:0]    rst_uut;
    logic [BW-1:0]    blk_uut;
    logic [KW-1:0]    key_uut;
    logic             enc_uut;
    logic [NU*BW-1:0] blk_from_uut;
    logic [NU-1:0]    end_uut;

    uut_test_sequencer_if #(.BLOCK_W(BW), .KEY_W(KW), .SEL_W(SW), .CNT_W(CW)) bus ();

    uut_test_sequencer #(
        .BLOCK_W(BW), .KEY_W(KW), .N_UUT(NU), .SEL_W(SW), .RST_CYCLES(RC), .CNT_W(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ctl              (bus),
        .rst_uut_o        (rst_uut),
        .block_uut_o      (blk_uut),
        .key_uut_o        (key_uut),
        .encdec_uut_o     (enc_uut),
        .block_uut_i      (blk_from_uut),
        .end_signal_uut_i (end_uut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] uut_fn(input logic [63:0] b, input logic [63:0] k,
                                           input logic e, input int idx);
        return e ? ((b ^ k) + 64'(idx + 1)) : ((b - k) ^ {32'(idx), 32'h5a5a_0f0f});
    endfunction

    // UUT models: end rises in the lat-th cycle after reset release (lat=0: never).
    int uut_lat[NU];
    bit uut_stale[NU];
    int uut_cnt[NU];

    always @(posedge clk)
        for (int k = 0; k < NU; k++)
            uut_cnt[k] <= rst_uut[k] ? 0 : uut_cnt[k] + 1;

    always_comb begin
        end_uut      = '0;
        blk_from_uut = '0;
        for (int k = 0; k < NU; k++) begin
            end_uut[k] = uut_stale[k] || (uut_lat[k] != 0 && uut_cnt[k] + 1 >= uut_lat[k]);
            blk_from_uut[k*BW +: BW] = uut_fn(blk_uut, key_uut, enc_uut, k);
        end
    end

    logic [63:0] exp_blk = '0;

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},    64'(bus.busy_o),    64'd0);
        check({tag, "_done"},    64'(bus.done_o),    64'd0);
        check({tag, "_tmo"},     64'(bus.timeout_o), 64'd0);
        check({tag, "_block"},   bus.block_o,        64'd0);
        check({tag, "_cycles"},  64'(bus.cycles_o),  64'd0);
        check({tag, "_rstuut"},  64'(rst_uut),       64'(3'b111));
        check({tag, "_blkuut"},  blk_uut,            64'd0);
        check({tag, "_keyuut"},  key_uut,            64'd0);
        check({tag, "_encuut"},  64'(enc_uut),       64'd0);
    endtask

    // Entered and left on a negedge; start is accepted at the following posedge.
    task automatic run_req(input int sel, input int lat, input int tmo, input bit stale,
                           input bit poke, input int budget);
        logic [63:0]   b, k;
        logic          e;
        logic [NU-1:0] oh;
        int            exp_cyc, cyc, rst_hi;
        bit            exp_to, released, others_ok, busy_ok, latch_ok;

        b = {$urandom, $urandom};
        k = {$urandom, $urandom};
        e = 1'($urandom_range(0, 1));
        for (int j = 0; j < NU; j++) begin
            uut_lat[j]   = $urandom_range(1, 30);
            uut_stale[j] = 1'($urandom_range(0, 1));
        end
        oh = '0;
        if (sel < NU) begin
            uut_lat[sel]   = lat;
            uut_stale[sel] = stale;
            oh[sel]        = 1'b1;
        end

        if (sel >= NU)                                begin exp_cyc = 0;   exp_to = 1'b1; end
        else if (stale)                               begin exp_cyc = 1;   exp_to = 1'b0; end
        else if (tmo != 0 && (lat == 0 || lat > tmo)) begin exp_cyc = tmo; exp_to = 1'b1; end
        else if (lat == 0)                            begin exp_cyc = -1;  exp_to = 1'b0; end
        else                                          begin exp_cyc = lat; exp_to = 1'b0; end

        bus.start_i   = 1'b1;
        bus.sel_i     = SW'(sel);
        bus.block_i   = b;
        bus.key_i     = k;
        bus.encdec_i  = e;
        bus.timeout_i = CW'(tmo);
        @(negedge clk);
        bus.start_i   = 1'b0;
        bus.block_i   = {$urandom, $urandom};
        bus.key_i     = {$urandom, $urandom};
        bus.encdec_i  = ~e;
        bus.sel_i     = SW'($urandom_range(0, 3));
        bus.timeout_i = CW'($urandom);

        cyc = 1; rst_hi = 0; released = 0; others_ok = 1; busy_ok = 1; latch_ok = 1;
        while (!bus.done_o && cyc < budget) begin
            if (!released && (rst_uut & oh) != 0) rst_hi++;
            else released = 1;
            if ((rst_uut | oh) != 3'b111) others_ok = 0;
            if (sel < NU && (blk_uut !== b || key_uut !== k || enc_uut !== e)) latch_ok = 0;
            if (!bus.busy_o) busy_ok = 0;
            if (poke && exp_cyc > 3 && cyc == RC + 2) begin
                bus.start_i = 1'b1;
                bus.block_i = {$urandom, $urandom};
                bus.key_i   = {$urandom, $urandom};
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 1'b0;

        if (exp_cyc < 0) begin
            check("hang_no_done", 64'(bus.done_o), 64'd0);
            check("hang_busy", 64'(busy_ok & bus.busy_o), 64'd1);
            check("hang_latched", 64'(latch_ok), 64'd1);
            return;
        end

        if (sel < NU) exp_blk = uut_fn(b, k, e, sel);
        check("done_time", 64'(cyc), (sel >= NU) ? 64'd1 : 64'(RC + exp_cyc + 1));
        check("timeout_o", 64'(bus.timeout_o), 64'(exp_to));
        check("cycles_o", 64'(bus.cycles_o), 64'(exp_cyc));
        check("block_o", bus.block_o, exp_blk);
        check("busy_run", 64'(busy_ok & bus.busy_o), 64'd1);
        check("others_rst", 64'(others_ok), 64'd1);
        check("rst_in_done", 64'(rst_uut), 64'(3'b111));
        if (sel < NU) begin
            check("rst_cycles", 64'(rst_hi), 64'(RC));
            check("latched", 64'(latch_ok), 64'd1);
        end
        @(negedge clk);
        check("done_pulse", 64'(bus.done_o), 64'd0);
        check("busy_clr", 64'(bus.busy_o), 64'd0);
        check("timeout_hold", 64'(bus.timeout_o), 64'(exp_to));
        check("block_hold", bus.block_o, exp_blk);
        check("cycles_hold", 64'(bus.cycles_o), 64'(exp_cyc));
    endtask

    initial begin
        int sel, lat, tmo;
        bit stale;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.sel_i     = '0;
        bus.block_i   = '0;
        bus.key_i     = '0;
        bus.encdec_i  = 1'b0;
        bus.timeout_i = '0;
        for (int j = 0; j < NU; j++) begin
            uut_lat[j]   = 0;
            uut_stale[j] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        run_req(0, 20, 0, 1'b0, 1'b0, 200);   // nominal latency 20
        run_req(2, 15, 0, 1'b0, 1'b0, 200);   // highest valid slice
        run_req(3, 10, 0, 1'b0, 1'b0, 200);   // out of range
        run_req(1, 0, 50, 1'b0, 1'b0, 200);   // hung UUT, timeout 50
        run_req(1, 7, 7, 1'b0, 1'b0, 200);    // end coincides with timeout
        run_req(0, 30, 0, 1'b1, 1'b0, 200);   // stale end before request
        run_req(2, 25, 0, 1'b0, 1'b1, 200);   // start ignored during RUN

        for (int i = 0; i < 30; i++) begin
            sel   = $urandom_range(0, 3);
            lat   = $urandom_range(1, 40);
            tmo   = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 40) : 0;
            stale = ($urandom_range(0, 7) == 0);
            run_req(sel, lat, tmo, stale, 1'b1, 200);
        end

        run_req(1, 0, 0, 1'b0, 1'b0, 10000);  // no timeout: waits indefinitely
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        check("abort_no_done", 64'(bus.done_o), 64'd0);
        rst     = 1'b0;
        exp_blk = '0;
        @(negedge clk);
        run_req(0, 5, 0, 1'b0, 1'b0, 200);
        run_req(2, 12, 20, 1'b0, 1'b0, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uut_test_sequencer.md
# uut_test_sequencer

Parametrised sequencer between the autotest/SD measurement logic and one of N block-cipher units under test. It latches a test vector and holds the selected UUT in reset for a fixed number of cycles. It then releases the UUT and waits for its end signal, with an optional timeout, while counting latency cycles. Finally it captures the UUT output and reports the result with a single-cycle done pulse. It replaces the fixed one-UUT, 128-bit direct wiring with a generic harness that adds multi-UUT selection, latency measurement and hang detection.

## Interface
- BLOCK_W, 128, data block width in bits
- KEY_W, 128, key width in bits
- N_UUT, 1, number of attached UUTs (1..16)
- SEL_W, 4, width of sel_i; must satisfy 2^SEL_W >= N_UUT
- RST_CYCLES, 4, cycles the selected UUT is held in reset before a run (>=1)
- CNT_W, 32, width of cycle counter and timeout
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- start_i  input  1  request pulse; sampled only in IDLE
- sel_i  input  SEL_W  UUT index for this request
- block_i  input  BLOCK_W  plaintext/ciphertext
- key_i  input  KEY_W  key
- encdec_i  input  1  mode bit passed to UUT
- timeout_i  input  CNT_W  max RUN cycles; 0 = no timeout
- busy_o  output  1  high from accept until done_o inclusive
- done_o  output  1  one-cycle result strobe
- timeout_o  output  1  result status; valid while done_o is high and held until the next accept
- block_o  output  BLOCK_W  captured UUT output; held until the next done_o
- cycles_o  output  CNT_W  measured latency; held until the next done_o
- rst_uut_o  output  N_UUT  per-UUT reset, active-high
- block_uut_o  output  BLOCK_W  block to all UUTs
- key_uut_o  output  KEY_W  key to all UUTs
- encdec_uut_o  output  1  mode to all UUTs
- block_uut_i  input  N_UUT*BLOCK_W  UUT outputs; UUT k occupies bits [k*BLOCK_W +: BLOCK_W]
- end_signal_uut_i  input  N_UUT  per-UUT completion flag

## Operation
- States: IDLE, RESET, RUN, DONE.
- Reset (async) values:
  - state IDLE.
  - rst_uut_o all ones.
  - busy_o, done_o and timeout_o 0.
  - block_o, cycles_o, block_uut_o and key_uut_o 0.
  - encdec_uut_o 0.
  - Internal counters 0.
- IDLE:
  - On start_i=1 with sel_i < N_UUT: latch sel, block, key, encdec and timeout into registers, then go to RESET.
  - The latched values drive block_uut_o, key_uut_o and encdec_uut_o unchanged until the next accept.
- Out-of-range request (sel_i >= N_UUT):
  - Go directly to DONE with timeout_o=1 and cycles_o=0; block_o is not updated.
  - No UUT reset line changes.
- RESET: rst_uut_o[sel]=1 for RST_CYCLES cycles, then go to RUN.
- RUN:
  - rst_uut_o[sel]=0; the counter increments every RUN cycle, starting at 1 in the first RUN cycle.
  - If end_signal_uut_i[sel]=1: capture block_uut_i[sel] into block_o and the counter value into cycles_o, set timeout_o=0, go to DONE.
  - Otherwise, if timeout≠0 and counter == timeout: capture as above, set timeout_o=1, go to DONE.
  - If end signal and timeout occur in the same cycle, the end signal wins (timeout_o=0).
  - The counter saturates at 2^CNT_W−1; with timeout=0 the block waits indefinitely.
- DONE: done_o=1 for one cycle, rst_uut_o[sel] returns to 1, go to IDLE.
- Unselected UUTs are held in reset at all times.
- start_i outside IDLE is ignored; no queueing.
- Asserting rst mid-run aborts the run: no done_o is produced and all outputs take their reset values.

## Timing
- start_i accepted at edge T: busy_o=1 from T+1.
- rst_uut_o[sel]=1 during cycles T+1 .. T+RST_CYCLES; RUN begins at T+RST_CYCLES+1.
- end_signal seen in the k-th RUN cycle: cycles_o=k, DONE (done_o=1) in the next cycle, busy_o=0 the cycle after.
- Minimum request-to-done is RST_CYCLES+2 cycles; back-to-back start is accepted the cycle after DONE.
- Out-of-range request: done_o at T+1.
- end_signal_uut_i is sampled only in RUN; a stale high value during RESET is ignored.

## Test plan
- N_UUT=1, RST_CYCLES=4: a UUT model raising end 20 cycles after reset release -> rst_uut_o high for exactly 4 cycles, cycles_o=20, block_o equals the model output, timeout_o=0, one done_o pulse.
- N_UUT=3, sel_i=2: only rst_uut_o[2] toggles and block_o comes from slice 2; with sel_i=3 -> done_o at T+1, timeout_o=1, cycles_o=0, rst_uut_o stays 3'b111.
- UUT never ends, timeout_i=50 -> done_o with timeout_o=1, cycles_o=50; with timeout_i=0 no done after 10,000 cycles and busy_o stays 1.
- end_signal asserted in the same cycle the counter reaches timeout_i=7 -> timeout_o=0, cycles_o=7.
- start_i pulsed during RUN is ignored, with no change to the latched block/key; rst asserted mid-RUN -> no done_o, all outputs return to reset values, and the next start runs normally.
- end_signal held high before the request -> not seen during RESET; detected in RUN cycle 1, giving cycles_o=1.
